codec_config_sequencer: RTL and testbench
=========================================

CODEC_CONFIG_SEQUENCER -- requirements
Module: codec_config_sequencer

Interface
REQ-001 Parameter DEV_ADDR, 8'h34: I2C write address byte (7-bit address plus R/W=0).
REQ-002 Parameter NUM_REGS, 10: number of 16-bit configuration words, 1..16.
REQ-003 Parameter MAX_RETRY, 3: retries per word after a NACK, 0..7.
REQ-004 inClock  in  1: single clock, same clock as the I2C transmitter.
REQ-005 resetN  in  1: asynchronous, active-low reset.
REQ-006 start  in  1: one-cycle pulse that begins a full configuration pass.
REQ-007 txReady  in  1: transmitter ready.
REQ-008 txAck  in  1: transmitter ack; 1 = slave ACKed the last byte.
REQ-009 txMode  out  2: transmitter mode: 0 start, 1 byte, 2 stop.
REQ-010 txData  out  8: byte to send.
REQ-011 txReset  out  1: active-high hold/reset of the transmitter.
REQ-012 busy  out  1: pass in progress.
REQ-013 done  out  1: sticky; pass completed.
REQ-014 error  out  1: sticky; a word exhausted its retries.

Function
REQ-015 Each word w[15:0] SHALL be sent as: START, DEV_ADDR, w[15:8], w[7:0], STOP.
REQ-016 FSM states SHALL be IDLE, LAUNCH, WAIT_LOW, WAIT_HIGH, NEXT, FINISH.
REQ-017 In IDLE, txReset=1 and busy=0; start moves to LAUNCH with word index 0, op 0 (START), retry 0, and clears done and error.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 In LAUNCH, txReset=0; the next cycle SHALL be WAIT_LOW.
REQ-020 WAIT_LOW SHALL hold until txReady=0, then move to WAIT_HIGH; this discards a stale ready left over from the previous op.
REQ-021 txMode and txData SHALL be Mealy outputs. In WAIT_HIGH with txReady=1 they SHALL already present the next op in that same cycle, so the transmitter never repeats an op.
REQ-022 Op sequence: START to ADDR to HI to LO to STOP.
REQ-023 After STOP, the index SHALL increment. If index = NUM_REGS-1, go to FINISH; otherwise continue with START of the next word.
REQ-024 When a byte op completes (txReady=1) with txAck=0, the next op SHALL be STOP and the retry count SHALL increment.
REQ-025 After that STOP, the same word SHALL restart from START if retry ≤ MAX_RETRY. Otherwise error=1 and the FSM goes to FINISH.
REQ-026 MAX_RETRY=0 means a single attempt with no retry.
REQ-027 FINISH SHALL set done=1 and txReset=1 for one cycle, then return to IDLE; done and error hold until the next start.
REQ-028 The retry counter SHALL be 3 bits and reset per word.
REQ-029 The index SHALL be 4 bits; no wrap beyond NUM_REGS-1.
REQ-030 start and txReady=1 arriving in the same cycle while busy: start is ignored and the sequence advances normally.

Reset
REQ-031 On resetN=0: state IDLE, txReset=1, txMode=0, txData=0, busy=0, done=0, error=0, index=0, retry=0.
REQ-032 resetN asserted mid-pass SHALL abort immediately; the I2C lines are released via txReset=1. No STOP is generated.

Structure
REQ-033 A shared package SHALL hold the mode encodings (START=0, BYTE=1, STOP=2), the FSM state and op enumerations, and the default DEV_ADDR.
REQ-034 One sub-module, codec_config_rom, SHALL map a 4-bit index combinationally to the 16-bit word.
REQ-035 The ROM defaults SHALL be the audio codec init table: 16'h1E00 reset first, 16'h1201 active last.

Verification
REQ-036 Scenario 1: reset, then start with a slave model always ACKing -> 10 words × 5 ops in order; first bytes 8'h34, 8'h1E, 8'h00; done=1, error=0.
REQ-037 Scenario 2: NACK on the HI byte of word 2, once -> STOP, then word 2 is resent from START; done=1, error=0.
REQ-038 Scenario 3: permanent NACK on the ADDR byte -> 4 attempts (MAX_RETRY=3), then error=1 and done=1, with txReset=1 after the final STOP.
REQ-039 Scenario 4: resetN pulsed low during the LO byte of word 5 -> all outputs at reset values within the same cycle; a later start begins at word 0.
REQ-040 Scenario 5: start re-pulsed while busy -> no effect on sequence or counters.
REQ-041 Scenario 6: check txMode in the txReady=1 cycle -> it equals the next op (e.g. 1 after START, 2 after LO); no duplicated START or STOP on the bus.

Source files
------------

// File: rtl/codec_config_sequencer_pkg.sv
// Shared encodings for the codec configuration sequencer: transmitter modes,
// FSM states, bus operations and the default codec write address.
package codec_config_sequencer_pkg;

    localparam logic [1:0] MODE_START = 2'd0;
    localparam logic [1:0] MODE_BYTE  = 2'd1;
    localparam logic [1:0] MODE_STOP  = 2'd2;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h34;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_NEXT      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        OP_START = 3'd0,
        OP_ADDR  = 3'd1,
        OP_HI    = 3'd2,
        OP_LO    = 3'd3,
        OP_STOP  = 3'd4
    } op_t;

    function automatic logic [1:0] op_mode(input op_t op);
        case (op)
            OP_START: op_mode = MODE_START;
            OP_STOP:  op_mode = MODE_STOP;
            default:  op_mode = MODE_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/codec_config_rom.sv
// Audio codec init table: {register address[6:0], value[8:0]} per word,
// starting with the reset write and ending with the activate write.
module codec_config_rom (
    input  logic [3:0]  i_index,
    output logic [15:0] o_word
);

    always_comb begin
        case (i_index)
            4'd0:    o_word = 16'h1E00;
            4'd1:    o_word = 16'h0017;
            4'd2:    o_word = 16'h0217;
            4'd3:    o_word = 16'h0479;
            4'd4:    o_word = 16'h0679;
            4'd5:    o_word = 16'h0812;
            4'd6:    o_word = 16'h0A06;
            4'd7:    o_word = 16'h0C00;
            4'd8:    o_word = 16'h0E01;
            4'd9:    o_word = 16'h1201;
            default: o_word = 16'h0000;
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Streams the codec init table to an I2C byte transmitter as
// START, address, high byte, low byte, STOP per word, retrying NACKed words.
module codec_config_sequencer
    import codec_config_sequencer_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int unsigned NUM_REGS  = 10,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       inClock,
    input  logic       resetN,
    input  logic       start,
    input  logic       txReady,
    input  logic       txAck,
    output logic [1:0] txMode,
    output logic [7:0] txData,
    output logic       txReset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] dbgState
);

    localparam logic [3:0] LAST_IDX  = 4'(NUM_REGS - 1);
    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    // Handshake: the transmitter takes txMode/txData in any cycle where
    // txReady=1 and txReset=0; txReady then drops while the op is on the bus.
    state_t      r_state;
    op_t         r_op;
    logic [3:0]  r_idx;
    logic [2:0]  r_retry;
    logic        r_nack;
    logic        r_give_up;
    logic        r_tx_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_error;

    logic [15:0] w_word;
    logic        w_op_done;
    logic        w_byte_nack;
    logic        w_last_try;
    op_t         w_next_op;
    op_t         w_disp_op;

    codec_config_rom u_rom (
        .i_index (r_idx),
        .o_word  (w_word)
    );

    assign w_op_done   = (r_state == ST_WAIT_HIGH) && txReady;
    assign w_byte_nack = w_op_done && !txAck &&
                         (r_op == OP_ADDR || r_op == OP_HI || r_op == OP_LO);
    // True while the STOP now on the bus ends the pass (last word or retries exhausted).
    assign w_last_try  = r_nack ? r_give_up : (r_idx == LAST_IDX);

    always_comb begin
        case (r_op)
            OP_START: w_next_op = OP_ADDR;
            OP_ADDR:  w_next_op = txAck ? OP_HI : OP_STOP;
            OP_HI:    w_next_op = txAck ? OP_LO : OP_STOP;
            OP_LO:    w_next_op = OP_STOP;
            default:  w_next_op = OP_START;
        endcase
    end

    // The next op is shown in the ready cycle itself so the transmitter never repeats one.
    assign w_disp_op = w_op_done ? w_next_op : r_op;

    always_comb begin
        txMode = op_mode(w_disp_op);
        case (w_disp_op)
            OP_ADDR: txData = DEV_ADDR;
            OP_HI:   txData = w_word[15:8];
            OP_LO:   txData = w_word[7:0];
            default: txData = 8'h00;
        endcase
    end

    // Holding the transmitter in reset during the final STOP's ready cycle stops it launching a stray START.
    assign txReset  = r_tx_reset | (w_op_done && r_op == OP_STOP && w_last_try);
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign dbgState = r_state;

    always_ff @(posedge inClock or negedge resetN) begin
        if (!resetN) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_START;
            r_idx      <= 4'd0;
            r_retry    <= 3'd0;
            r_nack     <= 1'b0;
            r_give_up  <= 1'b0;
            r_tx_reset <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LAUNCH;
                        r_op       <= OP_START;
                        r_idx      <= 4'd0;
                        r_retry    <= 3'd0;
                        r_nack     <= 1'b0;
                        r_give_up  <= 1'b0;
                        r_tx_reset <= 1'b0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                ST_LAUNCH: r_state <= ST_WAIT_LOW;
                ST_WAIT_LOW: begin
                    if (!txReady) r_state <= ST_WAIT_HIGH;
                end
                ST_WAIT_HIGH: begin
                    if (txReady) begin
                        r_op <= w_next_op;
                        if (w_byte_nack) begin
                            r_nack    <= 1'b1;
                            r_give_up <= (r_retry == RETRY_LIM);
                            if (r_retry != 3'd7) r_retry <= r_retry + 3'd1;
                        end
                        if (r_op == OP_STOP) begin
                            r_state    <= ST_NEXT;
                            r_tx_reset <= w_last_try;
                        end else begin
                            r_state <= ST_WAIT_LOW;
                        end
                    end
                end
                ST_NEXT: begin
                    if (r_nack) begin
                        if (r_give_up) begin
                            r_error <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_nack  <= 1'b0;
                            r_state <= ST_WAIT_LOW;
                        end
                    end else if (r_idx == LAST_IDX) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FINISH;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_retry <= 3'd0;
                        r_state <= ST_WAIT_LOW;
                    end
                end
                ST_FINISH: begin
                    r_tx_reset <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_config_sequencer.sv
// Bench for codec_config_sequencer: an I2C transmitter model with NACK injection
// checks every accepted bus op against a queue built from the word table.
module tb_codec_config_sequencer;

    logic       inClock;
    logic       resetN;
    logic       start;
    logic       txReady;
    logic       txAck;
    logic [1:0] txMode;
    logic [7:0] txData;
    logic       txReset;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbgState;

    codec_config_sequencer dut (
        .inClock  (inClock),
        .resetN   (resetN),
        .start    (start),
        .txReady  (txReady),
        .txAck    (txAck),
        .txMode   (txMode),
        .txData   (txData),
        .txReset  (txReset),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .dbgState (dbgState)
    );

    // ---------------- clock / reset ----------------
    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    // ---------------- scoreboard state ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [9:0] exp_q[$];
    logic [9:0] acc_log[8];
    int         n_acc   = 0;
    bit         lo5_seen = 0;

    // NACK plan: byte position (0 addr, 1 hi, 2 lo), data to match (-1 any), NACK count
    int p_pos  = 0;
    int p_data = -1;
    int p_left = 0;
    int t_left = 0;

    // transmitter model state
    int         cnt = 0;
    int         pos = 0;
    bit         cur_ack = 1'b1;
    logic       s_rst, s_rdy, s_rn;
    logic [1:0] s_mode;
    logic [7:0] s_data;

    function automatic logic [15:0] word_of(input int i);
        case (i)
            0: word_of = 16'h1E00;
            1: word_of = 16'h0017;
            2: word_of = 16'h0217;
            3: word_of = 16'h0479;
            4: word_of = 16'h0679;
            5: word_of = 16'h0812;
            6: word_of = 16'h0A06;
            7: word_of = 16'h0C00;
            8: word_of = 16'h0E01;
            9: word_of = 16'h1201;
            default: word_of = 16'h0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bus ops for one pass: per word START, ADDR, HI, LO, STOP; a NACKed
    // byte is followed directly by STOP and the word restarts until retries run out.
    task automatic build_exp(output int n, output bit err);
        int          left;
        int          tries;
        bit          nacked;
        bit          word_done;
        logic [15:0] wd;
        logic [7:0]  b;
        left = p_left;
        exp_q.delete();
        n   = 0;
        err = 1'b0;
        for (int w = 0; w < 10 && !err; w++) begin
            tries     = 0;
            word_done = 1'b0;
            wd        = word_of(w);
            while (!word_done && !err) begin
                exp_q.push_back(10'h000); n++;
                nacked = 1'b0;
                for (int p = 0; p < 3 && !nacked; p++) begin
                    b = (p == 0) ? 8'h34 : ((p == 1) ? wd[15:8] : wd[7:0]);
                    exp_q.push_back({2'd1, b}); n++;
                    if (left > 0 && p == p_pos && (p_data < 0 || p_data == int'(b))) begin
                        nacked = 1'b1;
                        left--;
                    end
                end
                exp_q.push_back(10'h200); n++;
                if (!nacked) word_done = 1'b1;
                else begin
                    tries++;
                    if (tries > 3) err = 1'b1;
                end
            end
        end
    endtask

    // ---------------- transmitter model + compare ----------------
    always @(negedge inClock) begin
        s_rst  = txReset;
        s_rdy  = txReady;
        s_rn   = resetN;
        s_mode = txMode;
        s_data = txData;
    end

    task automatic accept(input logic [1:0] mode, input logic [7:0] data);
        logic [9:0] e;
        if (n_acc < 8) acc_log[n_acc] = {mode, data};
        n_acc++;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_op: got unexpected op %0h with no op expected at %0t", {mode, data}, $time);
        end else begin
            e = exp_q.pop_front();
            check("bus_op", {22'd0, mode, data}, {22'd0, e});
        end
        cur_ack = 1'b1;
        if (mode == 2'd0) pos = 0;
        else if (mode == 2'd1) begin
            if (pos == 2 && data == 8'h12) lo5_seen = 1'b1;
            if (t_left > 0 && pos == p_pos && (p_data < 0 || p_data == int'(data))) begin
                cur_ack = 1'b0;
                t_left--;
            end
            pos++;
        end
    endtask

    initial begin : xmit
        txReady = 1'b1;
        txAck   = 1'b1;
        forever begin
            @(posedge inClock); #1;
            if (s_rst || !s_rn) begin
                txReady = 1'b1;
                txAck   = 1'b1;
                cnt     = 0;
            end else if (s_rdy) begin
                accept(s_mode, s_data);
                txReady = 1'b0;
                cnt     = $urandom_range(3, 6);
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    txReady = 1'b1;
                    txAck   = cur_ack;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(posedge inClock); #1 start = 1'b1;
        @(posedge inClock); #1 start = 1'b0;
    endtask

    task automatic wait_pass(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge inClock); #1;
            if (done && !busy) break;
        end
        check("pass_ends", 32'(k < budget), 32'd1);
    endtask

    task automatic set_plan(input int pp, input int pd, input int pl);
        p_pos  = pp;
        p_data = pd;
        p_left = pl;
        t_left = pl;
        n_acc  = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int n_exp;
        bit exp_err;
        bit hit;
        resetN = 1'b0;
        start  = 1'b0;
        repeat (3) @(posedge inClock);
        #1;
        check("rst_txReset", 32'(txReset), 32'd1);
        check("rst_txMode",  32'(txMode),  32'd0);
        check("rst_txData",  32'(txData),  32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_error",   32'(error),   32'd0);
        @(negedge inClock) resetN = 1'b1;
        repeat (2) @(posedge inClock);

        // scenario 1: always ACK
        set_plan(0, -1, 0);
        build_exp(n_exp, exp_err);
        check("s1_model_len", 32'(n_exp), 32'd50);
        pulse_start();
        wait_pass(3000);
        check("s1_ops",    32'(n_acc), 32'(n_exp));
        check("s1_q_left", 32'(exp_q.size()), 32'd0);
        check("s1_op0_start", 32'(acc_log[0]), 32'h000);
        check("s1_op1_addr",  32'(acc_log[1]), 32'h134);
        check("s1_op2_hi",    32'(acc_log[2]), 32'h11E);
        check("s1_op3_lo",    32'(acc_log[3]), 32'h100);
        check("s1_op4_stop",  32'(acc_log[4]), 32'h200);
        check("s1_op5_start", 32'(acc_log[5]), 32'h000);
        check("s1_done",    32'(done),    32'd1);
        check("s1_error",   32'(error),   32'(exp_err));
        check("s1_txReset", 32'(txReset), 32'd1);
        repeat (20) @(posedge inClock);
        #1 check("s1_no_extra_ops", 32'(n_acc), 32'd50);

        // scenario 2: one NACK on the HI byte of word 2
        set_plan(1, 8'h02, 1);
        build_exp(n_exp, exp_err);
        check("s2_model_len", 32'(n_exp), 32'd54);
        pulse_start();
        wait_pass(3000);
        check("s2_ops",    32'(n_acc), 32'(n_exp));
        check("s2_q_left", 32'(exp_q.size()), 32'd0);
        check("s2_done",   32'(done),  32'd1);
        check("s2_error",  32'(error), 32'(exp_err));

        // scenario 3: permanent NACK on the address byte
        set_plan(0, -1, 1000);
        build_exp(n_exp, exp_err);
        check("s3_model_len", 32'(n_exp), 32'd12);
        pulse_start();
        wait_pass(3000);
        check("s3_ops",     32'(n_acc), 32'(n_exp));
        check("s3_q_left",  32'(exp_q.size()), 32'd0);
        check("s3_done",    32'(done),    32'd1);
        check("s3_error",   32'(error),   32'd1);
        check("s3_model_err", 32'(exp_err), 32'd1);
        check("s3_txReset", 32'(txReset), 32'd1);

        // scenario 4: reset during the LO byte of word 5, then a fresh pass
        set_plan(0, -1, 0);
        build_exp(n_exp, exp_err);
        lo5_seen = 1'b0;
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 3000 && !hit; k++) begin
            @(posedge inClock); #1;
            hit = lo5_seen;
        end
        check("s4_reached_lo5", 32'(hit), 32'd1);
        @(posedge inClock); #2 resetN = 1'b0;
        #1;
        check("s4_txReset", 32'(txReset), 32'd1);
        check("s4_txMode",  32'(txMode),  32'd0);
        check("s4_txData",  32'(txData),  32'd0);
        check("s4_busy",    32'(busy),    32'd0);
        check("s4_done",    32'(done),    32'd0);
        check("s4_error",   32'(error),   32'd0);
        exp_q.delete();
        repeat (3) @(posedge inClock);
        @(negedge inClock) resetN = 1'b1;
        set_plan(0, -1, 0);
        build_exp(n_exp, exp_err);
        pulse_start();
        wait_pass(3000);
        check("s4_ops",    32'(n_acc), 32'(n_exp));
        check("s4_first_hi", 32'(acc_log[2]), 32'h11E);
        check("s4_q_left", 32'(exp_q.size()), 32'd0);
        check("s4_done",   32'(done), 32'd1);

        // scenario 5: start re-pulsed while busy, including in a ready cycle
        set_plan(0, -1, 0);
        build_exp(n_exp, exp_err);
        pulse_start();
        repeat (15) @(posedge inClock);
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge inClock); #2;
            if (txReady && dbgState == 3'd3) begin
                start = 1'b1;
                hit   = 1'b1;
                @(posedge inClock); #1 start = 1'b0;
            end
        end
        check("s5_ready_pulse", 32'(hit), 32'd1);
        repeat (40) @(posedge inClock);
        pulse_start();
        wait_pass(3000);
        check("s5_ops",    32'(n_acc), 32'(n_exp));
        check("s5_q_left", 32'(exp_q.size()), 32'd0);
        check("s5_done",   32'(done),  32'd1);
        check("s5_error",  32'(error), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
